// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: streams words into IMEM, reads them back
// against a rotate-XOR checksum, and enables the core only after a clean load.
`timescale 1ns/1ps

module imem_loader #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              stop,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [63:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic              cpu_enable,
    output logic              busy,
    output logic              error,
    output logic [DATA_W-1:0] csum
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] rsum_q, rsum_d;
    logic [DATA_W-1:0] rsum_fold;
    logic              start_ok;

    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] c,
                                               input logic [DATA_W-1:0] w);
        return {c[DATA_W-2:0], c[DATA_W-1]} ^ w;
    endfunction

    assign rsum_fold = fold(rsum_q, rdata_ext);
    assign start_ok  = (num_words != '0) && (num_words <= CNT_W'(DEPTH));
    assign csum      = csum_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            rsum_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            rsum_q  <= rsum_d;
        end
    end

    // Next state, datapath updates and memory-port outputs
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        rsum_d     = rsum_q;
        s_ready    = 1'b0;
        addr_ext   = '0;
        wen_ext    = 1'b0;
        ren_ext    = 1'b0;
        wdata_ext  = '0;
        cpu_enable = 1'b0;
        busy       = 1'b0;
        error      = 1'b0;

        case (state_q)
            ST_IDLE, ST_FAIL: begin
                error = (state_q == ST_FAIL);
                if (start) begin
                    if (start_ok) begin
                        n_d     = num_words;
                        idx_d   = '0;
                        csum_d  = '0;
                        rsum_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) begin
                    wen_ext   = 1'b1;
                    addr_ext  = 64'({idx_q, 2'b00});
                    wdata_ext = s_data;
                    csum_d    = fold(csum_q, s_data);
                    if (idx_q == n_q - CNT_W'(1)) begin
                        idx_d   = '0;
                        state_d = ST_VERIFY;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            ST_VERIFY: begin
                // idx runs 0..N: reads issue on 0..N-1, data folds on 1..N
                busy = 1'b1;
                if (idx_q < n_q) begin
                    ren_ext  = 1'b1;
                    addr_ext = 64'({idx_q, 2'b00});
                end
                if (idx_q != '0) begin
                    rsum_d = rsum_fold;
                end
                if (idx_q == n_q) begin
                    state_d = (rsum_fold == csum_q) ? ST_RUN : ST_FAIL;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cpu_enable = 1'b1;
                if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader with a behavioural IMEM model
// and a checksum reference computed from plain arithmetic over the word list.
`timescale 1ns/1ps

module tb_imem_loader;

    logic        clk;
    logic        arst;
    logic        start;
    logic [9:0]  num_words;
    logic        stop;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic        cpu_enable;
    logic        busy;
    logic        error;
    logic [31:0] csum;

    imem_loader #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk        (clk),
        .arst       (arst),
        .start      (start),
        .num_words  (num_words),
        .stop       (stop),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .rdata_ext  (rdata_ext),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error),
        .csum       (csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model with a write log and optional read corruption at byte addr 4
    logic [31:0] mem [0:511];
    logic [63:0] wr_addr [$];
    logic [31:0] wr_data [$];
    bit          corrupt;

    always @(posedge clk) begin
        if (wen_ext) begin
            mem[addr_ext[10:2]] <= wdata_ext;
            wr_addr.push_back(addr_ext);
            wr_data.push_back(wdata_ext);
        end
        if (ren_ext)
            rdata_ext <= mem[addr_ext[10:2]] ^ ((corrupt && addr_ext == 64'd4) ? 32'h0000_0100 : 32'h0);
    end

    int verify_cycles = 0;
    int wen_cnt = 0;
    int bad_wen = 0;

    always @(negedge clk) begin
        if (busy && !s_ready) verify_cycles++;
        if (wen_ext) wen_cnt++;
        if (wen_ext && !(s_valid && s_ready)) bad_wen++;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] words [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_csum(input int cnt);
        logic [31:0] c = 32'h0;
        for (int k = 0; k < cnt; k++)
            c = ((c << 1) | (c >> 31)) ^ words[k];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: s_valid held high, 1: pattern 1-0-0-1-0-1, 2: random
    task automatic do_load(input int mode, output int load_cycles);
        int  n   = words.size();
        int  wb  = wr_addr.size();
        int  vb  = verify_cycles;
        int  i   = 0;
        int  cyc = 0;
        int  w   = 0;
        int  bad = 0;
        bit  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        num_words = 10'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_entry_ready", 64'(s_ready), 64'd1);
        chk("load_entry_error", 64'(error), 64'd0);
        while (i < n && cyc < n * 20 + 50) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = pat[cyc % 6];
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = words[i];
            @(negedge clk);
            if (s_valid && s_ready) i++;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        s_data  = 32'h0;
        chk("load_words_accepted", 64'(i), 64'(n));
        while (busy && w < n + 20) begin
            tick();
            w++;
        end
        chk("verify_exit", 64'(busy), 64'd0);
        chk("wr_count", 64'(wr_addr.size() - wb), 64'(n));
        for (int k = 0; k < n && wb + k < wr_addr.size(); k++)
            if (wr_addr[wb + k] !== 64'(4 * k) || wr_data[wb + k] !== words[k]) bad++;
        chk("wr_log_bad_entries", 64'(bad), 64'd0);
        chk("verify_len", 64'(verify_cycles - vb), 64'(n + 1));
        load_cycles = cyc;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int lc;
        int wc0;
        arst = 1'b1; start = 1'b0; stop = 1'b0; num_words = '0;
        s_valid = 1'b0; s_data = '0; corrupt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_outputs", 64'({wen_ext, ren_ext, cpu_enable, busy, error}), 64'd0);
        chk("rst_csum", 64'(csum), 64'd0);
        arst = 1'b0;
        tick();

        // Basic N=3, s_valid held
        words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        do_load(0, lc);
        chk("held_load_cycles", 64'(lc), 64'd3);
        chk("held_csum_const", 64'(csum), 64'h3333_3333);
        chk("held_csum_ref", 64'(csum), 64'(ref_csum(3)));
        chk("held_run", 64'({cpu_enable, error}), 64'b10);
        num_words = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("run_ignores_start", 64'({cpu_enable, error}), 64'b10);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_cpu_enable", 64'(cpu_enable), 64'd0);
        chk("stop_to_idle", 64'({s_ready, busy, error}), 64'd0);

        // Same load with toggling s_valid
        do_load(1, lc);
        chk("toggle_csum", 64'(csum), 64'h3333_3333);
        chk("toggle_bad_wen", 64'(bad_wen), 64'd0);
        chk("toggle_run", 64'(cpu_enable), 64'd1);
        stop_run();

        // Randomized loads
        for (int r = 0; r < 3; r++) begin
            int n = $urandom_range(1, 40);
            words.delete();
            for (int k = 0; k < n; k++) words.push_back($urandom);
            do_load(2, lc);
            chk("rand_csum", 64'(csum), 64'(ref_csum(n)));
            chk("rand_run", 64'({cpu_enable, error}), 64'b10);
            stop_run();
        end
        chk("rand_bad_wen", 64'(bad_wen), 64'd0);

        // Illegal word counts
        wc0 = wen_cnt;
        num_words = 10'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("zero_error", 64'({error, cpu_enable, busy}), 64'b100);
        arst = 1'b1;
        tick();
        arst = 1'b0;
        tick();
        num_words = 10'd513;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("over_error", 64'({error, cpu_enable, busy}), 64'b100);
        chk("illegal_no_write", 64'(wen_cnt - wc0), 64'd0);

        // Corrupted readback, then clean retry from FAIL
        words.delete();
        for (int k = 0; k < 4; k++) words.push_back($urandom);
        corrupt = 1'b1;
        do_load(0, lc);
        chk("corrupt_fail", 64'({error, cpu_enable}), 64'b10);
        corrupt = 1'b0;
        do_load(2, lc);
        chk("retry_run", 64'({error, cpu_enable}), 64'b01);
        chk("retry_csum", 64'(csum), 64'(ref_csum(4)));
        stop_run();

        // Asynchronous reset mid-load after the 2nd handshake
        words = '{32'hA5A5_0001, 32'h0F0F_1234, 32'h5555_AAAA, 32'h1234_5678, 32'hDEAD_BEEF};
        num_words = 10'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = words[0];
        tick();
        s_data = words[1];
        tick();
        s_data = words[2];
        #1;
        chk("midload_wen", 64'(wen_ext), 64'd1);
        chk("midload_csum", 64'(csum), 64'(ref_csum(2)));
        arst = 1'b1;
        #1;
        chk("arst_async_ctrl", 64'({s_ready, wen_ext, ren_ext, cpu_enable, busy, error}), 64'd0);
        chk("arst_async_data", 64'({addr_ext, wdata_ext, csum}), 64'd0);
        s_valid = 1'b0;
        tick();
        arst = 1'b0;
        tick();
        chk("arst_idle", 64'({s_ready, busy, error}), 64'd0);

        // Full-depth load, word i = i
        words.delete();
        for (int k = 0; k < 512; k++) words.push_back(32'(k));
        do_load(0, lc);
        chk("full_last_addr", wr_addr[wr_addr.size() - 1], 64'h7FC);
        chk("full_csum", 64'(csum), 64'(ref_csum(512)));
        chk("full_run", 64'({cpu_enable, error}), 64'b10);
        chk("full_bad_wen", 64'(bad_wen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
